dot_matrix_scan: RTL and testbench
==================================

Name: dot_matrix_scan

Overview:
Parametrised successor to the organ's single-note dot-matrix driver. Scans a ROWS x COLS bicolour LED matrix with a programmable row dwell and shows up to CHANNELS simultaneous notes (chords). Supports bar or dot display mode, and a per-channel release hold. Sits between the key/playback note sources and the matrix pins.

Parameters:
ROWS, 8, matrix rows scanned; must be >= 7.
COLS, 8, matrix columns; must be >= 7.
CHANNELS, 2, number of simultaneous note channels, 1..4.
DWELL, 1024, clk cycles each row stays active; must be >= 2.
HOLD_FRAMES, 16, frames a released note stays lit; 0 means no hold.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous assert, active-low (0 = reset).
value_in  in  3*CHANNELS  per-channel note: 001 = do .. 111 = si; 000 = no note. Channel k is at bits [3k+2:3k].
tone_in  in  2*CHANNELS  per-channel octave: 00 low, 10 mid, 11 high; 01 is treated as mid.
mode  in  1  0 = bar, 1 = dot.
blank  in  1  1 = all LEDs off; scanning continues.
row  out  ROWS  row select, active-low one-hot.
line_r  out  COLS  red column drive, active-high.
line_g  out  COLS  green column drive, active-high.
frame_start  out  1  one-cycle pulse when row index wraps to 0.

Behaviour:
- Reset (rst=0), asynchronous:
  - row = all ones; line_r = line_g = 0; frame_start = 0.
  - Prescaler = 0; row index = 0.
  - Shadow value/tone = 0; hold counters = 0.
- Prescaler counts 0..DWELL-1. At DWELL-1 it wraps to 0, and the row index advances 0..ROWS-1, wrapping to 0.
- frame_start = 1 for exactly one cycle, in the cycle the row index becomes 0. The first frame_start occurs DWELL*ROWS cycles after reset release.
- Frame-boundary latch, per channel, on the frame_start cycle only (no tearing):
  - value_in != 0: shadow value/tone <= inputs; hold <= HOLD_FRAMES.
  - value_in == 0 and hold > 0: hold decrements; shadow retained.
  - value_in == 0 and hold == 0: shadow value <= 0.
  - Input changes mid-frame have no effect until the next frame boundary.
- A channel is active if its shadow value v != 0. For active channels:
  - Lit column = v-1 (do = column 0).
  - Bar mode: lit in rows r >= ROWS-v.
  - Dot mode: lit only in row ROWS-v.
- Colour by shadow tone:
  - 00: green only.
  - 10 or 01: red only.
  - 11: red and green.
- Channels mapping to the same pixel are OR-combined per colour plane.
- Output timing: row, line_r and line_g are registered and change together one cycle after a row index change. No row is ever driven with the previous row's column data.
- blank=1: the next cycle forces row = all ones and lines = 0. Prescaler, row index and latch logic continue. Release restores the display at the next row update.
- Reset asserted mid-frame: immediate return to reset values; the first frame after release starts at row 0.
- DWELL and HOLD counters are sized with $clog2; no overflow is possible.

Decomposition:
- Shared package dot_matrix_pkg:
  - tone codes TONE_LOW = 2'b00, TONE_MID = 2'b10, TONE_HIGH = 2'b11.
  - NOTE_NONE = 3'b000.
  - Colour-plane function mapping tone to {r,g}.
- One sub-module: dot_matrix_scan_timer (prescaler plus row counter). Outputs the row index, a row-advance strobe and frame_start.
- Latch, hold and pixel generation stay in the top module.

Test Plan:
Bench parameters: DWELL=2, ROWS=8, COLS=8, CHANNELS=2, HOLD_FRAMES=2.
1. Reset: hold rst=0 for 3 cycles, then release -> row=8'hFF, lines=0. First frame_start arrives 16 cycles after release, then repeats every 16 cycles.
2. Channel 0 value=3, tone=00, mode=0, latched at a frame boundary -> in the next frame, rows 5..7 show line_g=8'b0000_0100 and line_r=0; rows 0..4 show lines 0.
3. Same input with mode=1 -> only row 5 shows line_g=8'h04.
4. Channel 0 value=1, tone=11; channel 1 value=1, tone=00 -> row 7 shows line_r=8'h01 and line_g=8'h01.
5. Channel 0 value changes 5 -> 0 at a frame boundary -> the note stays displayed for 2 more frames, then goes dark. A value_in change in mid-frame is not visible until the next frame_start.
6. blank pulsed high for 5 cycles during an active row -> row=8'hFF and lines=0 within 1 cycle. frame_start period is unchanged; display resumes at the next row update.

Source files
------------

// File: rtl/dot_matrix_pkg.sv
// Shared definitions for the dot-matrix note display: tone and note codes
// plus the mapping from a tone to the colour planes it lights.
package dot_matrix_pkg;

    localparam logic [1:0] TONE_LOW  = 2'b00;
    localparam logic [1:0] TONE_MID  = 2'b10;
    localparam logic [1:0] TONE_HIGH = 2'b11;

    localparam logic [2:0] NOTE_NONE = 3'b000;

    typedef struct packed {
        logic red;
        logic green;
    } colour_t;

    // Low octave is green, high octave is both planes (amber), anything else
    // (mid, and the unused 01 code) is red.
    function automatic colour_t toneColour(input logic [1:0] tone);
        colour_t c;
        c.red   = 1'b0;
        c.green = 1'b0;
        case (tone)
            TONE_LOW:  c.green = 1'b1;
            TONE_HIGH: begin
                c.red   = 1'b1;
                c.green = 1'b1;
            end
            default:   c.red = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dot_matrix_scan_timer.sv
// Row scan timing: a dwell prescaler feeding a row counter. Publishes the
// current row index, a strobe in the first cycle of every new row, and a
// strobe in the first cycle of every new frame (row index back at 0).
module dot_matrix_scan_timer #(
    parameter int ROWS  = 8,
    parameter int DWELL = 1024,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [ROW_W-1:0] o_rowIdx,
    output logic             o_rowAdv,
    output logic             o_frameStart
);

    localparam int PRE_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [PRE_W-1:0] r_presc;
    logic [ROW_W-1:0] r_rowIdx;
    logic             r_rowAdv;
    logic             r_frameStart;
    logic             w_presWrap;
    logic             w_rowWrap;

    assign w_presWrap = (r_presc == PRE_W'(DWELL - 1));
    assign w_rowWrap  = (r_rowIdx == ROW_W'(ROWS - 1));

    // Prescaler and row counter; the strobes are registered so they line up
    // with the cycle in which the new row index is already visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc      <= '0;
            r_rowIdx     <= '0;
            r_rowAdv     <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_rowAdv     <= w_presWrap;
            r_frameStart <= w_presWrap & w_rowWrap;
            if (w_presWrap) begin
                r_presc  <= '0;
                r_rowIdx <= w_rowWrap ? '0 : r_rowIdx + ROW_W'(1);
            end else begin
                r_presc  <= r_presc + PRE_W'(1);
            end
        end
    end

    assign o_rowIdx     = r_rowIdx;
    assign o_rowAdv     = r_rowAdv;
    assign o_frameStart = r_frameStart;

endmodule

// File: rtl/dot_matrix_scan.sv
// Multi-channel note display for a bicolour LED matrix. Note inputs are
// latched once per frame into per-channel shadows with a release hold, and
// each row's column drive is generated from the shadows as the row comes up.
module dot_matrix_scan
    import dot_matrix_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int CHANNELS    = 2,
    parameter int DWELL       = 1024,
    parameter int HOLD_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*CHANNELS-1:0] value_in,
    input  logic [2*CHANNELS-1:0] tone_in,
    input  logic                  mode,
    input  logic                  blank,
    output logic [ROWS-1:0]       row,
    output logic [COLS-1:0]       line_r,
    output logic [COLS-1:0]       line_g,
    output logic                  frame_start
);

    localparam int ROW_W  = $clog2(ROWS);
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic [ROW_W-1:0]  w_rowIdx;
    logic              w_rowAdv;
    logic              w_frameStart;

    logic [2:0]        r_shVal  [CHANNELS];
    logic [1:0]        r_shTone [CHANNELS];
    logic [HOLD_W-1:0] r_hold   [CHANNELS];
    logic [2:0]        w_nxVal  [CHANNELS];
    logic [1:0]        w_nxTone [CHANNELS];
    logic [HOLD_W-1:0] w_nxHold [CHANNELS];

    logic [ROWS-1:0]   w_rowSel;
    logic [COLS-1:0]   w_pixR;
    logic [COLS-1:0]   w_pixG;

    logic [ROWS-1:0]   r_row;
    logic [COLS-1:0]   r_lineR;
    logic [COLS-1:0]   r_lineG;

    dot_matrix_scan_timer #(
        .ROWS  (ROWS),
        .DWELL (DWELL),
        .ROW_W (ROW_W)
    ) u_timer (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .o_rowIdx     (w_rowIdx),
        .o_rowAdv     (w_rowAdv),
        .o_frameStart (w_frameStart)
    );

    // Next shadow state: inputs are only sampled on the frame boundary, so a
    // whole frame is always drawn from one consistent set of notes.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            w_nxVal[k]  = r_shVal[k];
            w_nxTone[k] = r_shTone[k];
            w_nxHold[k] = r_hold[k];
            if (w_frameStart) begin
                if (value_in[3*k +: 3] != NOTE_NONE) begin
                    w_nxVal[k]  = value_in[3*k +: 3];
                    w_nxTone[k] = tone_in[2*k +: 2];
                    w_nxHold[k] = HOLD_INIT;
                end else if (r_hold[k] != '0) begin
                    w_nxHold[k] = r_hold[k] - HOLD_W'(1);
                end else begin
                    w_nxVal[k]  = NOTE_NONE;
                end
            end
        end
    end

    // Shadow note registers with their release-hold counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shVal[k]  <= NOTE_NONE;
                r_shTone[k] <= TONE_LOW;
                r_hold[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_shVal[k]  <= w_nxVal[k];
                r_shTone[k] <= w_nxTone[k];
                r_hold[k]   <= w_nxHold[k];
            end
        end
    end

    // Active-low row select for the current row index.
    always_comb begin
        w_rowSel = '1;
        for (int r = 0; r < ROWS; r++) begin
            w_rowSel[r] = (int'(w_rowIdx) != r);
        end
    end

    // Column drive for the current row. Uses the next shadow state so row 0
    // of a new frame already reflects the notes latched at that boundary.
    always_comb begin
        logic [2:0] v;
        colour_t    col;
        logic       rowHit;
        int         thresh;
        w_pixR = '0;
        w_pixG = '0;
        v      = NOTE_NONE;
        col    = '0;
        rowHit = 1'b0;
        thresh = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            v      = w_nxVal[k];
            col    = toneColour(w_nxTone[k]);
            thresh = ROWS - int'(v);
            rowHit = mode ? (int'(w_rowIdx) == thresh) : (int'(w_rowIdx) >= thresh);
            if (v != NOTE_NONE && rowHit) begin
                for (int c = 0; c < COLS; c++) begin
                    if (int'(v) == c + 1) begin
                        w_pixR[c] = w_pixR[c] | col.red;
                        w_pixG[c] = w_pixG[c] | col.green;
                    end
                end
            end
        end
    end

    // Pin registers: row and columns move together at each row update, and
    // blanking overrides them every cycle it is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row   <= '1;
            r_lineR <= '0;
            r_lineG <= '0;
        end else if (blank) begin
            r_row   <= '1;
            r_lineR <= '0;
            r_lineG <= '0;
        end else if (w_rowAdv) begin
            r_row   <= w_rowSel;
            r_lineR <= w_pixR;
            r_lineG <= w_pixG;
        end
    end

    assign row         = r_row;
    assign line_r      = r_lineR;
    assign line_g      = r_lineG;
    assign frame_start = w_frameStart;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Scoreboard bench for dot_matrix_scan: the stimulus side queues the rows it
// expects to see each frame, and a monitor checks every new row presentation.
module tb_dot_matrix_scan;

    logic       clk;
    logic       rst;
    logic [5:0] value_in;
    logic [3:0] tone_in;
    logic       mode;
    logic       blank;
    logic [7:0] row;
    logic [7:0] line_r;
    logic [7:0] line_g;
    logic       frame_start;

    typedef struct {
        logic [7:0] rowV;
        logic [7:0] lr;
        logic [7:0] lg;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         cycleCnt    = 0;
    int         lastFs      = 0;
    logic [7:0] prevRow     = 8'hFF;

    dot_matrix_scan #(
        .ROWS        (8),
        .COLS        (8),
        .CHANNELS    (2),
        .DWELL       (2),
        .HOLD_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .tone_in     (tone_in),
        .mode        (mode),
        .blank       (blank),
        .row         (row),
        .line_r      (line_r),
        .line_g      (line_g),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to measure frame_start spacing.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Monitor: each time a new row is driven, pop and compare one entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && row !== prevRow && row !== 8'hFF) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL rowUnexpected: got row=%h r=%h g=%h, required no row update",
                         row, line_r, line_g);
            end else begin
                monE = expQ.pop_front();
                if ({row, line_r, line_g} !== {monE.rowV, monE.lr, monE.lg}) begin
                    nMismatched++;
                    $display("[TB] FAIL rowData: got row=%h r=%h g=%h, required row=%h r=%h g=%h",
                             row, line_r, line_g, monE.rowV, monE.lr, monE.lg);
                end
            end
        end
        prevRow = row;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v0, input logic [1:0] t0,
                                 input logic [2:0] v1, input logic [1:0] t1,
                                 input logic m);
        value_in = {v1, v0};
        tone_in  = {t1, t0};
        mode     = m;
    endtask

    // Queue the rows expected in one frame: present selects which row
    // indices will actually be driven, litMask which of them carry lr/lg,
    // and r7/g7 are extra bits OR-ed into row 7.
    task automatic pushRows(input logic [7:0] present, input logic [7:0] litMask,
                            input logic [7:0] lr, input logic [7:0] lg,
                            input logic [7:0] r7, input logic [7:0] g7);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            if (present[r]) begin
                e.rowV    = 8'hFF;
                e.rowV[r] = 1'b0;
                e.lr      = litMask[r] ? lr : 8'h00;
                e.lg      = litMask[r] ? lg : 8'h00;
                if (r == 7) begin
                    e.lr = e.lr | r7;
                    e.lg = e.lg | g7;
                end
                expQ.push_back(e);
            end
        end
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        if (frame_start !== 1'b1) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL frameTimeout: got no frame_start in %0d cycles, required one within 16", n);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
            $finish;
        end
        checkOutput("framePeriod", cycleCnt - lastFs, 16);
        lastFs = cycleCnt;
    endtask

    initial begin
        rst = 1'b0;
        blank = 1'b0;
        applyStimulus(3'd0, 2'b00, 3'd0, 2'b00, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("resetRow", row, 8'hFF);
        checkOutput("resetLines", {line_r, line_g}, 16'h0000);
        checkOutput("resetFrameStart", frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        lastFs = cycleCnt;
        pushRows(8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Frame 1: single green bar, do=1 .. mi=3 -> column 2, rows 5..7.
        waitFrame();
        applyStimulus(3'd3, 2'b00, 3'd0, 2'b00, 1'b0);
        pushRows(8'hFF, 8'hE0, 8'h00, 8'h04, 8'h00, 8'h00);

        // Frame 2: same note in dot mode -> row 5 only.
        waitFrame();
        applyStimulus(3'd3, 2'b00, 3'd0, 2'b00, 1'b1);
        pushRows(8'hFF, 8'h20, 8'h00, 8'h04, 8'h00, 8'h00);

        // Frame 3: chord on the same pixel, high + low -> both planes.
        waitFrame();
        applyStimulus(3'd1, 2'b11, 3'd1, 2'b00, 1'b0);
        pushRows(8'hFF, 8'h80, 8'h01, 8'h01, 8'h00, 8'h00);

        // Frame 4: ch0 red sol=5 (rows 3..7), ch1 released but held.
        waitFrame();
        applyStimulus(3'd5, 2'b10, 3'd0, 2'b00, 1'b0);
        pushRows(8'hFF, 8'hF8, 8'h10, 8'h00, 8'h00, 8'h01);

        // Frame 5: ch0 released (hold 1 left), ch1 on last held frame.
        waitFrame();
        applyStimulus(3'd0, 2'b00, 3'd0, 2'b00, 1'b0);
        pushRows(8'hFF, 8'hF8, 8'h10, 8'h00, 8'h00, 8'h01);

        // Frame 6: ch1 gone, ch0 on its last held frame.
        waitFrame();
        pushRows(8'hFF, 8'hF8, 8'h10, 8'h00, 8'h00, 8'h00);

        // Frame 7: everything dark.
        waitFrame();
        pushRows(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Frame 8: a mid-frame note must not appear in this frame.
        waitFrame();
        pushRows(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        applyStimulus(3'd6, 2'b11, 3'd0, 2'b00, 1'b0);

        // Frame 9: la=6 amber, rows 2..7; blank swallows rows 2..4.
        waitFrame();
        pushRows(8'hE3, 8'hFC, 8'h20, 8'h20, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        checkOutput("blankRow", row, 8'hFF);
        checkOutput("blankLines", {line_r, line_g}, 16'h0000);
        repeat (3) @(negedge clk);
        @(negedge clk);
        blank = 1'b0;
        @(negedge clk);
        checkOutput("blankUntilRowUpdate", row, 8'hFF);

        // Frame 10: held note; reset is asserted mid-frame after row 2.
        waitFrame();
        applyStimulus(3'd0, 2'b00, 3'd0, 2'b00, 1'b0);
        pushRows(8'h07, 8'hFC, 8'h20, 8'h20, 8'h00, 8'h00);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midResetRow", row, 8'hFF);
        checkOutput("midResetLines", {line_r, line_g}, 16'h0000);
        checkOutput("midResetFrameStart", frame_start, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        lastFs = cycleCnt;
        pushRows(8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        waitFrame();
        checkOutput("queueDrained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Overall watchdog so the run always terminates.
    initial begin
        #100000;
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL watchdog: got run still active at %0t, required completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
